// File: rtl/display_msg_scheduler_pkg.sv
// display_msg_scheduler_pkg: message ids, FSM states, character codes and
// the active-low character-to-segment table shared by the display scheduler.
package display_msg_scheduler_pkg;

    localparam logic [3:0] MSG_S0   = 4'd0;
    localparam logic [3:0] MSG_S1   = 4'd1;
    localparam logic [3:0] MSG_S2   = 4'd2;
    localparam logic [3:0] MSG_S3   = 4'd3;
    localparam logic [3:0] MSG_ERSR = 4'd4;
    localparam logic [3:0] MSG_ERSP = 4'd5;
    localparam logic [3:0] MSG_ERSN = 4'd6;
    localparam logic [3:0] MSG_ERDI = 4'd7;
    localparam logic [3:0] MSG_STBY = 4'd8;

    typedef enum logic [1:0] {
        ST_STBY = 2'd0,
        ST_SEL  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        CH_C     = 4'd0,
        CH_E     = 4'd1,
        CH_L     = 4'd2,
        CH_R     = 4'd3,
        CH_S     = 4'd4,
        CH_P     = 4'd5,
        CH_N     = 4'd6,
        CH_D     = 4'd7,
        CH_I     = 4'd8,
        CH_0     = 4'd9,
        CH_1     = 4'd10,
        CH_2     = 4'd11,
        CH_5     = 4'd12,
        CH_DASH  = 4'd13,
        CH_BLANK = 4'd14
    } char_t;

    // Active-low segments, bit order gfedcba, indexed by char_t.
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000110, // C
        7'b0000110, // E
        7'b1000111, // L
        7'b0101111, // r
        7'b0010010, // S
        7'b0001100, // P
        7'b0101011, // n
        7'b0100001, // d
        7'b1111001, // I
        7'b1000000, // 0
        7'b1111001, // 1
        7'b0100100, // 2
        7'b0010010, // 5
        7'b0111111, // -
        7'b1111111, // blank
        7'b1111111  // unused code
    };

    function automatic char_t msg_char(input logic [3:0] msg,
                                       input logic [1:0] idx);
        char_t row [4];
        case (msg)
            MSG_S0:   row = '{CH_C, CH_E, CH_0, CH_1};
            MSG_S1:   row = '{CH_C, CH_L, CH_0, CH_2};
            MSG_S2:   row = '{CH_C, CH_C, CH_0, CH_5};
            MSG_S3:   row = '{CH_C, CH_P, CH_1, CH_0};
            MSG_ERSR: row = '{CH_E, CH_R, CH_S, CH_R};
            MSG_ERSP: row = '{CH_E, CH_R, CH_S, CH_P};
            MSG_ERSN: row = '{CH_E, CH_R, CH_S, CH_N};
            MSG_ERDI: row = '{CH_E, CH_R, CH_D, CH_I};
            MSG_STBY: row = '{CH_DASH, CH_DASH, CH_DASH, CH_DASH};
            default:  row = '{CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK};
        endcase
        return row[idx];
    endfunction

    // Lower rank = higher priority: errors 0..3, selections 4..7, standby 8.
    function automatic logic [3:0] msg_rank(input logic [3:0] msg);
        if (msg >= MSG_ERSR && msg <= MSG_ERDI) return msg - MSG_ERSR;
        if (msg <= MSG_S3) return msg + 4'd4;
        return 4'd8;
    endfunction

endpackage

// File: rtl/msg_char_rom.sv
// msg_char_rom: registered (message, digit) -> {segments, dp} lookup.
// Ports: clk_i/rst_i, msg_i, idx_i in; seg_o (gfedcba, active-low), dp_o out.
module msg_char_rom
    import display_msg_scheduler_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] msg_i,
    input  logic [1:0] idx_i,
    output logic [6:0] seg_o,
    output logic       dp_o
);

    logic [6:0] seg_q;
    logic       dp_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            seg_q <= SEG_TAB[msg_char(msg_i, idx_i)];
            // Decimal point lit only on the rightmost digit in standby.
            dp_q  <= ~(msg_i == MSG_STBY && idx_i == 2'd3);
        end
    end

    assign seg_o = seg_q;
    assign dp_o  = dp_q;

endmodule

// File: rtl/display_msg_scheduler.sv
// display_msg_scheduler: picks the message owning the 4-digit display, holds
// it, and scans digits. In: CLK, RST, S0..S3, SR/SP/SN, VL, M.
// Out: a..g, h (active-low), DIG (active-low, [0]=left), MSG (debug id).
module display_msg_scheduler
    import display_msg_scheduler_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       S0,
    input  logic       S1,
    input  logic       S2,
    input  logic       S3,
    input  logic       SR,
    input  logic       SP,
    input  logic       SN,
    input  logic       VL,
    input  logic       M,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h,
    output logic [3:0] DIG,
    output logic [3:0] MSG
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_t        state_q;
    logic [3:0]    msg_q, msg_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [SW-1:0] scan_q;
    logic [1:0]    idx_q;
    logic [3:0]    dig_q;
    logic [3:0]    best;
    logic          any_sel;
    logic          preempt;
    logic          hold_done;
    logic [6:0]    seg;
    logic          dp;

    assign any_sel = S0 | S1 | S2 | S3;

    // Selection branches are reached only with VL=1, since a selection
    // without VL already matched the ERDI branch.
    always_comb begin
        best = MSG_STBY;
        priority case (1'b1)
            SR:            best = MSG_ERSR;
            SP:            best = MSG_ERSP;
            SN:            best = MSG_ERSN;
            any_sel & ~VL: best = MSG_ERDI;
            S0:            best = MSG_S0;
            S1:            best = MSG_S1;
            S2:            best = MSG_S2;
            S3:            best = MSG_S3;
            default:       best = MSG_STBY;
        endcase
    end

    assign preempt = (best[3:2] == 2'b01) &&
                     (msg_rank(best) < msg_rank(msg_q));

    // Expiring one count early keeps a message up exactly HOLD_CYCLES.
    assign hold_done = (hold_q >= HOLD_LAST);

    always_comb begin
        msg_d = msg_q;
        if (!M)
            msg_d = MSG_STBY;
        else if (state_q == ST_STBY || preempt || hold_done)
            msg_d = best;
    end

    always_comb begin
        hold_d = hold_q;
        if (msg_d != msg_q)
            hold_d = '0;
        else if (hold_q != HOLD_MAX)
            hold_d = hold_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_STBY;
            msg_q   <= MSG_STBY;
            hold_q  <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            dig_q   <= 4'b1111;
        end else begin
            msg_q  <= msg_d;
            hold_q <= hold_d;
            unique case (1'b1)
                msg_d == MSG_STBY:   state_q <= ST_STBY;
                msg_d[3:2] == 2'b01: state_q <= ST_ERR;
                default:             state_q <= ST_SEL;
            endcase
            if (scan_q == SCAN_LAST) begin
                scan_q <= '0;
                idx_q  <= idx_q + 2'd1;
            end else begin
                scan_q <= scan_q + 1'b1;
            end
            // Registered alongside the ROM so DIG lines up with a..h.
            dig_q <= ~(4'b0001 << idx_q);
        end
    end

    msg_char_rom u_msg_char_rom (
        .clk_i (CLK),
        .rst_i (RST),
        .msg_i (msg_q),
        .idx_i (idx_q),
        .seg_o (seg),
        .dp_o  (dp)
    );

    assign {g, f, e, d, c, b, a} = seg;
    assign h   = dp;
    assign DIG = dig_q;
    assign MSG = msg_q;

endmodule

// File: tb/tb_display_msg_scheduler.sv
// tb_display_msg_scheduler: directed checks of arbitration, hold, preemption,
// standby override, reset and digit scanning with SCAN_DIV=4, HOLD_CYCLES=16.
module tb_display_msg_scheduler;

    localparam logic [6:0] K_C    = 7'b1000110;
    localparam logic [6:0] K_E    = 7'b0000110;
    localparam logic [6:0] K_L    = 7'b1000111;
    localparam logic [6:0] K_R    = 7'b0101111;
    localparam logic [6:0] K_S    = 7'b0010010;
    localparam logic [6:0] K_P    = 7'b0001100;
    localparam logic [6:0] K_0    = 7'b1000000;
    localparam logic [6:0] K_2    = 7'b0100100;
    localparam logic [6:0] K_DASH = 7'b0111111;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic S0 = 1'b0, S1 = 1'b0, S2 = 1'b0, S3 = 1'b0;
    logic SR = 1'b0, SP = 1'b0, SN = 1'b0;
    logic VL = 1'b0, M = 1'b1;
    logic a, b, c, d, e, f, g, h;
    logic [3:0] DIG, MSG;
    logic [6:0] segs;

    int n_chk = 0;
    int n_fail = 0;
    int cyc;
    logic [6:0] ersp [4] = '{K_E, K_R, K_S, K_P};

    assign segs = {g, f, e, d, c, b, a};

    always #5 CLK = ~CLK;

    // Rising edges since reset release; drives the expected digit slot.
    always @(posedge CLK) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    display_msg_scheduler #(
        .SCAN_DIV    (4),
        .HOLD_CYCLES (16)
    ) dut (
        .CLK (CLK), .RST (RST),
        .S0 (S0), .S1 (S1), .S2 (S2), .S3 (S3),
        .SR (SR), .SP (SP), .SN (SN), .VL (VL), .M (M),
        .a (a), .b (b), .c (c), .d (d), .e (e), .f (f), .g (g), .h (h),
        .DIG (DIG), .MSG (MSG)
    );

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic int cur_digit();
        return ((cyc - 1) >> 2) % 4;
    endfunction

    task automatic wait_digit(input int j);
        for (int k = 0; k < 20; k++) begin
            if (cyc >= 1 && cur_digit() == j) break;
            step(1);
        end
    endtask

    task automatic show(input string tag, input logic [6:0] ch0,
                        input logic [6:0] ch1, input logic [6:0] ch2,
                        input logic [6:0] ch3, input logic dp3);
        logic [6:0] ex [4];
        logic [3:0] en;
        logic       dpx;
        ex = '{ch0, ch1, ch2, ch3};
        for (int j = 0; j < 4; j++) begin
            wait_digit(j);
            en  = ~(4'b0001 << j);
            dpx = (j == 3) ? dp3 : 1'b1;
            chk({tag, "_dig"}, 32'(DIG), 32'(en));
            chk({tag, "_seg"}, 32'(segs), 32'(ex[j]));
            chk({tag, "_dp"}, 32'(h), 32'(dpx));
        end
    endtask

    initial begin
        // Reset state
        step(3);
        chk("rst_msg", 32'(MSG), 8);
        chk("rst_dig", 32'(DIG), 32'hF);
        chk("rst_seg", 32'(segs), 32'h7F);
        chk("rst_dp", 32'(h), 1);
        RST = 1'b0;

        // Standby scan: dashes, DP on rightmost digit only
        step(1);
        chk("stby_msg", 32'(MSG), 8);
        show("stby", K_DASH, K_DASH, K_DASH, K_DASH, 1'b0);

        // Selection CL02 content
        S1 = 1'b1; VL = 1'b1;
        step(1);
        chk("cl02_msg", 32'(MSG), 1);
        step(1);
        show("cl02", K_C, K_L, K_0, K_2, 1'b1);
        step(16);
        S1 = 1'b0;
        step(1);
        chk("cl02_drop", 32'(MSG), 8);

        // Short selection request held for the full hold time
        S1 = 1'b1;
        step(1);
        chk("hold_start", 32'(MSG), 1);
        step(2);
        S1 = 1'b0;
        step(13);
        chk("hold_last", 32'(MSG), 1);
        step(1);
        chk("hold_expire", 32'(MSG), 8);

        // ERDI then a lower-priority selection waits for hold
        S2 = 1'b1; VL = 1'b0;
        step(1);
        chk("erdi_msg", 32'(MSG), 7);
        step(2);
        VL = 1'b1;
        step(13);
        chk("erdi_hold", 32'(MSG), 7);
        step(1);
        chk("erdi_to_sel2", 32'(MSG), 2);
        S2 = 1'b0;
        step(20);
        chk("back_stby", 32'(MSG), 8);

        // One-cycle SP pulse preempts CE01 and is held 16 cycles
        S0 = 1'b1;
        step(1);
        chk("ce01_msg", 32'(MSG), 0);
        step(2);
        SP = 1'b1;
        step(1);
        chk("ersp_preempt", 32'(MSG), 5);
        SP = 1'b0;
        step(2);
        chk("ersp_seg", 32'(segs), 32'(ersp[cur_digit()]));
        step(13);
        chk("ersp_hold", 32'(MSG), 5);
        step(1);
        chk("ersp_to_ce01", 32'(MSG), 0);

        // Simultaneous SR/SN, then M=0 override
        SR = 1'b1; SN = 1'b1;
        step(1);
        chk("srsn_msg", 32'(MSG), 4);
        step(2);
        M = 1'b0;
        step(1);
        chk("m0_stby", 32'(MSG), 8);
        step(2);
        chk("m0_err_stby", 32'(MSG), 8);
        M = 1'b1;
        step(1);
        chk("m1_ersr", 32'(MSG), 4);
        step(1);
        show("ersr", K_E, K_R, K_S, K_R, 1'b1);
        step(16);
        SR = 1'b0;
        step(1);
        chk("ersn_msg", 32'(MSG), 6);

        // Reset mid-hold
        step(3);
        RST = 1'b1;
        step(1);
        chk("mrst_msg", 32'(MSG), 8);
        chk("mrst_dig", 32'(DIG), 32'hF);
        chk("mrst_seg", 32'(segs), 32'h7F);
        chk("mrst_dp", 32'(h), 1);
        RST = 1'b0;
        step(1);
        chk("rel_dig", 32'(DIG), 32'hE);
        chk("rel_msg", 32'(MSG), 6);
        chk("rel_seg", 32'(segs), 32'(K_DASH));
        step(1);
        chk("rel_seg2", 32'(segs), 32'(K_E));
        chk("rel_dig2", 32'(DIG), 32'hE);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
